// File: rtl/mem_stage_mc.sv
// mem_stage_mc: multi-cycle MEM stage with req/ack data bus, load extension, store strobes and timeout.
// Optional performance counters are built when MEM_STAGE_PERF_EN is defined.
module mem_stage_mc #(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32,
    parameter int MAX_WAIT = 15,
    localparam int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_mem_en,
    input  logic              in_mem_rw,
    input  logic [2:0]        in_rw_type,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              stall_out,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_rdata,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_rdata
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_accesses
`endif
);
    localparam int OFF_W = $clog2(STRB_W);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        ld_type;
    logic [OFF_W-1:0]  ld_off;
    logic [OFF_W-1:0]  off;
    logic              live, aligned, issue, finish;
    logic [XLEN-1:0]   wdata_lane, shifted, lmask, ext;
    logic [STRB_W-1:0] strb_lane;
    logic              sign;

    // Mask covering the low 1/2/4/8 bytes of a word, selected by rw_type[1:0].
    function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] sz);
        return {XLEN{1'b1}} >> (7'(XLEN) - (7'd8 << sz));
    endfunction

    assign live = in_valid & in_mem_en;
    assign off = in_addr[OFF_W-1:0];
    // 111 is unassigned and D/WU only exist on a 64-bit datapath, so those count as misaligned.
    assign aligned = in_rw_type[1:0] == 2'd0 ? 1'b1 :
                     in_rw_type[1:0] == 2'd1 ? ~in_addr[0] :
                     in_rw_type == 3'b010    ? in_addr[1:0] == 2'b00 :
                     in_rw_type == 3'b110    ? XLEN == 64 && in_addr[1:0] == 2'b00 :
                     in_rw_type == 3'b011    ? XLEN == 64 && in_addr[2:0] == 3'b000 : 1'b0;
    assign issue = state == IDLE & live & aligned;
    assign finish = bus_ack | cnt == CNT_W'(MAX_WAIT - 1);
    assign wdata_lane = (in_wdata & lane_mask(in_rw_type[1:0])) << {off, 3'b000};
    assign strb_lane = STRB_W'({8{1'b1}} >> (4'd8 - (4'd1 << in_rw_type[1:0]))) << off;
    assign shifted = bus_rdata >> {ld_off, 3'b000};
    assign lmask = lane_mask(ld_type[1:0]);
    assign sign = ~ld_type[2] & |(shifted & lmask & ~(lmask >> 1));
    assign ext = (shifted & lmask) | ({XLEN{sign}} & ~lmask);

    // Next state, pipeline stall and completion strobe.
    always_comb begin
        state_n = state == IDLE ? (issue ? WAIT : IDLE) :
                  state == WAIT ? (finish ? DONE : WAIT) : IDLE;
        stall_out = ~rst & (state == WAIT | issue);
        out_valid = state == DONE;
    end

    // State register.
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // Bus request registers, wait counter, load result and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ld_type <= '0;
            ld_off <= '0;
            out_rdata <= '0;
            misalign_err <= 1'b0;
            bus_err <= 1'b0;
            bus_req <= 1'b0;
            bus_we <= 1'b0;
            bus_addr <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
        end else begin
            misalign_err <= state == IDLE & live & ~aligned;
            bus_err <= 1'b0;
            if (issue) begin
                bus_req <= 1'b1;
                bus_we <= in_mem_rw;
                bus_addr <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                bus_wdata <= in_mem_rw ? wdata_lane : '0;
                bus_wstrb <= in_mem_rw ? strb_lane : '0;
                ld_type <= in_rw_type;
                ld_off <= off;
                cnt <= '0;
            end else if (state == WAIT) begin
                if (finish) begin
                    bus_req <= 1'b0;
                    bus_we <= 1'b0;
                    bus_addr <= '0;
                    bus_wdata <= '0;
                    bus_wstrb <= '0;
                    bus_err <= ~bus_ack;
                    out_rdata <= bus_ack & ~bus_we ? ext : '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (state == DONE) begin
                out_rdata <= '0;
            end
        end
    end

`ifdef MEM_STAGE_PERF_EN
    // Stall-cycle and issued-access counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_accesses <= '0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + {31'd0, stall_out};
            perf_accesses <= perf_accesses + {31'd0, issue};
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc: vector table, corner sequences and random transactions against an arithmetic model.
module tb_mem_stage_mc;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_mem_en = 1'b0, in_mem_rw = 1'b0;
    logic [2:0]  in_rw_type = 3'd0;
    logic [31:0] in_addr = '0, in_wdata = '0;
    logic        stall_out, out_valid, misalign_err, bus_err, bus_req, bus_we;
    logic [31:0] out_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    int          checks = 0, failures = 0;

    typedef struct {
        logic        rw;
        logic [2:0]  ty;
        logic [31:0] addr, wdata, rdata;
        int          delay;
        logic        mis;
        logic [31:0] e_rdata, e_addr, e_wdata;
        logic [3:0]  e_strb;
        logic        e_err;
    } vec_t;

    vec_t tbl[13];

    mem_stage_mc #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_en(in_mem_en), .in_mem_rw(in_mem_rw),
        .in_rw_type(in_rw_type), .in_addr(in_addr), .in_wdata(in_wdata), .stall_out(stall_out),
        .out_valid(out_valid), .out_rdata(out_rdata), .misalign_err(misalign_err), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_stall"}, stall_out, 0);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_rdata"}, out_rdata, 0);
        chk({nm, "_mis"}, misalign_err, 0);
        chk({nm, "_berr"}, bus_err, 0);
        chk({nm, "_req"}, bus_req, 0);
        chk({nm, "_we"}, bus_we, 0);
        chk({nm, "_addr"}, bus_addr, 0);
        chk({nm, "_wdata"}, bus_wdata, 0);
        chk({nm, "_wstrb"}, bus_wstrb, 0);
    endtask

    // Expected results straight from the byte-lane arithmetic of each access type.
    function automatic vec_t model(input vec_t v);
        int sz, off;
        longint span, val;
        sz = 1 << (v.ty % 4);
        off = int'(v.addr % 4);
        v.mis = v.ty == 3'd3 || v.ty >= 3'd6 || (v.addr % sz) != 0;
        span = longint'(1) << (8 * sz);
        v.e_addr = v.addr - off;
        v.e_strb = v.rw ? 4'(((1 << sz) - 1) << off) : 4'h0;
        v.e_wdata = v.rw ? 32'((longint'(v.wdata) % span) << (8 * off)) : 32'h0;
        v.e_err = v.delay >= MW;
        val = (longint'(v.rdata) >> (8 * off)) % span;
        if (v.ty < 3'd4 && val >= span / 2) val -= span;
        v.e_rdata = (v.rw || v.e_err) ? 32'h0 : val[31:0];
        return v;
    endfunction

    // Runs one live instruction from its issue cycle to completion; starts and ends just after a rising edge.
    task automatic run(input vec_t v);
        in_valid = 1'b1; in_mem_en = 1'b1; in_mem_rw = v.rw; in_rw_type = v.ty;
        in_addr = v.addr; in_wdata = v.wdata;
        bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        @(negedge clk);
        chk("issue_stall", stall_out, !v.mis);
        chk("issue_req", bus_req, 0);
        chk("issue_mis", misalign_err, 0);
        if (v.mis) begin
            next_cycle();
            in_valid = 1'b0; bus_ack = 1'b0;
            @(negedge clk);
            chk("mis_pulse", misalign_err, 1);
            chk("mis_req", bus_req, 0);
            chk("mis_stall", stall_out, 0);
            chk("mis_valid", out_valid, 0);
            next_cycle();
            return;
        end
        for (int w = 0; w < MW; w++) begin
            next_cycle();
            bus_ack = w == v.delay;
            bus_rdata = bus_ack ? v.rdata : $urandom;
            @(negedge clk);
            chk("wait_stall", stall_out, 1);
            chk("wait_req", bus_req, 1);
            chk("wait_we", bus_we, v.rw);
            chk("wait_addr", bus_addr, v.e_addr);
            chk("wait_wdata", bus_wdata, v.e_wdata);
            chk("wait_wstrb", bus_wstrb, v.e_strb);
            chk("wait_valid", out_valid, 0);
            if (bus_ack) break;
        end
        next_cycle();
        bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        @(negedge clk);
        chk("done_valid", out_valid, 1);
        chk("done_stall", stall_out, 0);
        chk("done_req", bus_req, 0);
        chk("done_wstrb", bus_wstrb, 0);
        chk("done_rdata", out_rdata, v.e_rdata);
        chk("done_berr", bus_err, v.e_err);
        next_cycle();
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 32'h100, 32'h0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, 32'hFFFFFF80, 32'h100, 32'h0, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 32'h00000080, 32'h100, 32'h0, 4'h0, 1'b0};
        tbl[3]  = '{1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 2, 1'b0, 32'h0, 32'h200, 32'hABCD0000, 4'hC, 1'b0};
        tbl[4]  = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0};
        tbl[5]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h11111111, 9, 1'b0, 32'h0, 32'h100, 32'h0, 4'h0, 1'b1};
        tbl[6]  = '{1'b1, 3'b010, 32'h204, 32'h12345678, 32'h0, 0, 1'b0, 32'h0, 32'h204, 32'h12345678, 4'hF, 1'b0};
        tbl[7]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 3, 1'b0, 32'hFFFF8001, 32'h100, 32'h0, 4'h0, 1'b0};
        tbl[8]  = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 1, 1'b0, 32'h00008001, 32'h100, 32'h0, 4'h0, 1'b0};
        tbl[9]  = '{1'b1, 3'b000, 32'h301, 32'hFFFFFFA5, 32'h0, 1, 1'b0, 32'h0, 32'h300, 32'h0000A500, 4'h2, 1'b0};
        tbl[10] = '{1'b0, 3'b011, 32'h108, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0};
        tbl[11] = '{1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0};
        tbl[12] = '{1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFF7FFF, 0, 1'b0, 32'h00007FFF, 32'h100, 32'h0, 4'h0, 1'b0};

        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        next_cycle();

        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_mem_en = !in_valid;
            in_mem_rw = 1'($urandom_range(0, 1));
            in_rw_type = 3'b010;
            in_addr = 32'h101;
            bus_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("nonmem_stall", stall_out, 0);
            chk("nonmem_req", bus_req, 0);
            chk("nonmem_valid", out_valid, 0);
            chk("nonmem_mis", misalign_err, 0);
            next_cycle();
        end

        foreach (tbl[i]) run(tbl[i]);

        in_valid = 1'b1; in_mem_en = 1'b1; in_mem_rw = 1'b0; in_rw_type = 3'b010;
        in_addr = 32'h100; bus_ack = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("rstwait_req", bus_req, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_all_zero("rstwait");
        next_cycle();
        run(tbl[0]);

        for (int i = 0; i < 60; i++) begin
            v.rw = 1'($urandom_range(0, 1));
            v.ty = 3'($urandom_range(0, 7));
            v.addr = $urandom & 32'h0000_0FFF;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.delay = $urandom_range(0, 5);
            run(model(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
